if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/control path.
- Generates the fetch PC, issues requests to instruction memory over a valid/ready request and valid response handshake, and buffers returned words in a small in-order queue.
- Presents the queue head to decode as instruction, PC and valid.
- Honours redirects, kills and stalls coming back from the control path.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_inst_queue.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_unit_pkg;

  // Redirect select encodings driven by the control path.
  localparam int                      EXE_PC_SEL_W = 2;
  localparam logic [EXE_PC_SEL_W-1:0] PC_SEL_PC4   = 2'b00;
  localparam logic [EXE_PC_SEL_W-1:0] PC_SEL_BR    = 2'b01;
  localparam logic [EXE_PC_SEL_W-1:0] PC_SEL_JR    = 2'b10;

  // addi x0,x0,0 shown to decode while nothing valid is buffered.
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // One buffered fetch: the instruction word and the PC it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } q_entry_t;

endpackage

// File: rtl/if_fetch_unit_inst_queue.sv
// In-order FIFO of {inst, pc} pairs between instruction memory and decode.
// Flush wins over push/pop; push and pop together on a full queue is legal.
module if_inst_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  q_entry_t         i_push_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output q_entry_t         o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  q_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: generates the fetch PC, requests words from
// instruction memory, buffers responses and presents the head to decode.
//
// Handshakes: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1; while valid=1 and ready=0 the address is held
// unless a redirect occurs. Responses have no back-pressure: each cycle with
// imem_resp_valid=1 delivers exactly one word, in request order. Decode
// consumes the presented instruction on an edge where fetch_valid=1 and
// neither stall is asserted.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [EXE_PC_SEL_W-1:0] CtoD_exe_pc_sel,
  input  logic [31:0]             exe_br_target,
  input  logic [31:0]             exe_jr_target,
  input  logic                    CtoD_if_kill,
  input  logic                    CtoD_dec_stall,
  input  logic                    CtoD_full_stall,
  output logic                    imem_req_valid,
  output logic [31:0]             imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_resp_valid,
  input  logic [31:0]             imem_resp_data,
  output logic [31:0]             fetch_inst,
  output logic [31:0]             fetch_pc,
  output logic                    fetch_valid,
  output fetch_state_e            dbg_state
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_req_valid;
  logic             w_hs;
  logic             w_pop;
  logic             w_push;
  logic             w_resp_live;
  logic             w_resp_drop;
  logic             w_credit_ok;
  logic [CNT_W-1:0] w_drop_nxt;
  logic [CNT_W-1:0] w_inflight_nxt;
  q_entry_t         w_push_entry;
  q_entry_t         w_head;
  logic             w_q_full;
  logic             w_q_empty;
  logic [CNT_W-1:0] w_q_count;

  assign w_redirect  = (CtoD_exe_pc_sel != PC_SEL_PC4) || CtoD_if_kill;
  assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
  assign w_resp_live = imem_resp_valid && (r_drop_cnt == '0);
  assign w_push      = w_resp_live && !w_redirect;
  assign w_pop       = fetch_valid && !CtoD_dec_stall && !CtoD_full_stall;
  assign w_hs        = w_req_valid && imem_req_ready;

  // Each request reserves a queue slot. The slot freed by this cycle's pop is
  // already counted as available, which sustains one fetch per cycle.
  assign w_credit_ok = (int'(r_inflight) + int'(w_q_count) + int'(r_drop_cnt)
                        - int'(w_pop) < QDEPTH) && !(w_q_full && !w_pop);

  // Responses already owed to the old path become drops on a redirect.
  assign w_drop_nxt     = r_drop_cnt - CNT_W'(w_resp_drop)
                          + (w_redirect ? (r_inflight - CNT_W'(w_resp_live)) : '0);
  assign w_inflight_nxt = w_redirect ? '0
                          : (r_inflight + CNT_W'(w_hs) - CNT_W'(w_resp_live));

  // Redirect target; JALR targets are halfword-aligned by clearing bit 0.
  always_comb begin
    w_target = r_pc;
    case (CtoD_exe_pc_sel)
      PC_SEL_BR: w_target = exe_br_target;
      PC_SEL_JR: w_target = {exe_jr_target[31:1], 1'b0};
      default:   w_target = r_pc;
    endcase
  end

  // Next-state and request-valid logic.
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_req_valid = !w_redirect && w_credit_ok;
        if (w_redirect && (w_drop_nxt != '0)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_req_valid = !w_redirect && w_credit_ok;
        if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Fetch PC and outstanding-response bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (w_redirect) r_pc <= w_target;
      else if (w_hs)  r_pc <= r_pc + 32'd4;
    end
  end

  // Request addresses are issued in order, so the queue tail's PC is the
  // address of the oldest live response: track it as pc minus live inflight.
  assign w_push_entry.inst = imem_resp_data;
  assign w_push_entry.pc   = r_pc - {r_inflight, 2'b00};

  if_inst_queue #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (w_redirect),
    .o_head       (w_head),
    .o_full       (w_q_full),
    .o_empty      (w_q_empty),
    .o_count      (w_q_count)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign fetch_valid    = !w_q_empty;
  assign fetch_inst     = w_q_empty ? NOP_INST : w_head.inst;
  assign fetch_pc       = w_q_empty ? 32'h0 : w_head.pc;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with random latency, a
// scoreboard of the PCs decode should see, directed scenarios, random phase.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   CtoD_exe_pc_sel;
  logic [31:0]  exe_br_target;
  logic [31:0]  exe_jr_target;
  logic         CtoD_if_kill;
  logic         CtoD_dec_stall;
  logic         CtoD_full_stall;
  logic         imem_req_valid;
  logic [31:0]  imem_req_addr;
  logic         imem_req_ready;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic [31:0]  fetch_inst;
  logic [31:0]  fetch_pc;
  logic         fetch_valid;
  fetch_state_e dbg_state;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (RST_PC),
    .QDEPTH   (2),
    .NOP_INST (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .CtoD_exe_pc_sel (CtoD_exe_pc_sel),
    .exe_br_target   (exe_br_target),
    .exe_jr_target   (exe_jr_target),
    .CtoD_if_kill    (CtoD_if_kill),
    .CtoD_dec_stall  (CtoD_dec_stall),
    .CtoD_full_stall (CtoD_full_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fetch_inst      (fetch_inst),
    .fetch_pc        (fetch_pc),
    .fetch_valid     (fetch_valid),
    .dbg_state       (dbg_state)
  );

  // ---------------- models and scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];     // accepted requests awaiting their response
  logic [31:0] exp_q[$];     // PCs decode is expected to consume next
  logic [31:0] hs_log[$];    // addresses of accepted requests
  logic [31:0] exp_next;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc, last_due, lat_min, lat_max, pops, first_valid_cyc;
  logic        last_req_valid, last_fetch_valid, hold_pend, stall_pend;
  logic [31:0] last_req_addr, last_pop_pc, hold_addr, stall_pc, stall_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    CtoD_exe_pc_sel = 2'b00;
    CtoD_if_kill    = 1'b0;
    CtoD_dec_stall  = 1'b0;
    CtoD_full_stall = 1'b0;
    exe_br_target   = 32'h0;
    exe_jr_target   = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    mem_q.delete();
    exp_q.delete();
    hs_log.delete();
    exp_next        = RST_PC;
    last_due        = -1;
    first_valid_cyc = -1;
    hold_pend       = 1'b0;
    stall_pend      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // One clock cycle: inputs are set by the caller at the falling edge; this
  // adds the memory response, samples and checks, then waits one cycle.
  task automatic cycle();
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] e;
    mreq_t       r;
    int          lat;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      r = mem_q.pop_front();
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom();
    end
    #1;
    redir = (CtoD_exe_pc_sel != 2'b00) || CtoD_if_kill;
    tgt   = (CtoD_exe_pc_sel == 2'b10) ? {exe_jr_target[31:1], 1'b0} : exe_br_target;
    if (redir) begin
      check("req_idle_on_redirect", imem_req_valid, 1'b0);
    end else begin
      if (hold_pend) begin
        check("req_held_valid", imem_req_valid, 1'b1);
        check("req_held_addr", imem_req_addr, hold_addr);
      end
      if (stall_pend) begin
        check("stall_valid", fetch_valid, 1'b1);
        check("stall_pc", fetch_pc, stall_pc);
        check("stall_inst", fetch_inst, stall_inst);
      end
    end
    hold_pend  = imem_req_valid && !imem_req_ready;
    hold_addr  = imem_req_addr;
    stall_pend = fetch_valid && (CtoD_dec_stall || CtoD_full_stall) && !redir;
    stall_pc   = fetch_pc;
    stall_inst = fetch_inst;
    if (!fetch_valid) check("nop_when_empty", fetch_inst, NOP);
    else if (first_valid_cyc < 0) first_valid_cyc = cyc;
    if (imem_req_valid && imem_req_ready) begin
      lat    = int'($urandom_range(lat_max, lat_min));
      r.addr = imem_req_addr;
      r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      mem_q.push_back(r);
      hs_log.push_back(imem_req_addr);
    end
    if (redir) begin
      exp_q.delete();
      exp_next = tgt;
    end else if (fetch_valid && !CtoD_dec_stall && !CtoD_full_stall) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
      e = exp_q.pop_front();
      check("fetch_pc", fetch_pc, e);
      check("fetch_inst", fetch_inst, mem_word(e));
      last_pop_pc = fetch_pc;
      pops++;
    end
    last_req_valid   = imem_req_valid;
    last_req_addr    = imem_req_addr;
    last_fetch_valid = fetch_valid;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jr);
    CtoD_exe_pc_sel = sel;
    exe_br_target   = br;
    exe_jr_target   = jr;
    cycle();
    CtoD_exe_pc_sel = 2'b00;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
    int p0;
    int budget;
    p0 = pops;
    budget = 40;
    while (pops == p0 && budget > 0) begin
      cycle();
      budget--;
    end
    if (pops == p0) check({tag, "_timeout"}, 32'd0, 32'd1);
    else            check(tag, last_pop_pc, exp_pc);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    int p0;
    int pick;
    logic [31:0] tmp;
    pops = 0;
    lat_min = 1;
    lat_max = 1;
    reset_dut();

    // Reset state observed before any fetch activity.
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_fetch_valid", fetch_valid, 1'b0);
    check("rst_fetch_inst", fetch_inst, NOP);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_BOOT));
    @(negedge clk);
    rst_n = 1'b0;
    reset_dut();

    // Always-ready memory with latency 1.
    repeat (8) cycle();
    check("t1_first_valid_cyc", first_valid_cyc, 3);
    check("t1_req0", hs_log[0], 32'h0);
    check("t1_req1", hs_log[1], 32'h4);
    check("t1_req2", hs_log[2], 32'h8);
    check("t1_pops", pops, 5);

    // Decode stall fills the queue and blocks issue.
    CtoD_dec_stall = 1'b1;
    repeat (4) cycle();
    check("t2_req_blocked", last_req_valid, 1'b0);
    check("t2_head_valid", last_fetch_valid, 1'b1);
    CtoD_dec_stall = 1'b0;
    p0 = pops;
    repeat (6) cycle();
    check("t2_resume_pops", pops - p0, 6);

    // Branch with two requests in flight, latency 3.
    lat_min = 3;
    lat_max = 3;
    budget = 20;
    while (mem_q.size() < 2 && budget > 0) begin
      cycle();
      budget--;
    end
    check("t3_two_inflight", mem_q.size(), 2);
    redirect(2'b01, 32'h100, 32'h0);
    wait_pop("t3_first_pc", 32'h100);

    // JALR in the same cycle as a response.
    lat_min = 2;
    lat_max = 2;
    budget = 20;
    while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && budget > 0) begin
      cycle();
      budget--;
    end
    hs_log.delete();
    redirect(2'b10, 32'h0, 32'h203);
    budget = 20;
    while (hs_log.size() == 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check("t4_req_addr", hs_log[0], 32'h202);
    wait_pop("t4_first_pc", 32'h202);

    // Memory not ready for 5 cycles.
    imem_req_ready = 1'b0;
    budget = 20;
    while (mem_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    redirect(2'b01, 32'h10, 32'h0);
    hs_log.delete();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t5_req_valid", last_req_valid, 1'b1);
      check("t5_req_addr", last_req_addr, 32'h10);
    end
    check("t5_no_hs", hs_log.size(), 0);
    imem_req_ready = 1'b1;
    cycle();
    check("t5_one_hs", hs_log.size(), 1);
    check("t5_hs_addr", hs_log[0], 32'h10);
    wait_pop("t5_first_pc", 32'h10);

    // Asynchronous reset while draining.
    lat_min = 4;
    lat_max = 4;
    budget = 30;
    while (!(mem_q.size() >= 2 && mem_q[0].due > cyc) && budget > 0) begin
      cycle();
      budget--;
    end
    redirect(2'b01, 32'h400, 32'h0);
    #1;
    check("t6_drain", 32'(dbg_state), 32'(ST_DRAIN));
    #1 rst_n = 1'b0;
    #1;
    check("t6_req_valid", imem_req_valid, 1'b0);
    check("t6_fetch_valid", fetch_valid, 1'b0);
    check("t6_fetch_inst", fetch_inst, NOP);
    check("t6_fetch_pc", fetch_pc, 32'h0);
    check("t6_state", 32'(dbg_state), 32'(ST_BOOT));
    reset_dut();
    lat_min = 1;
    lat_max = 1;
    repeat (6) cycle();
    check("t6_restart_addr", hs_log[0], RST_PC);
    check("t6_first_valid_cyc", first_valid_cyc, 3);

    // Random traffic.
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        lat_min = 1;
        lat_max = int'($urandom_range(1, 4));
      end
      imem_req_ready  = ($urandom_range(0, 9) < 7);
      CtoD_dec_stall  = ($urandom_range(0, 9) < 2);
      CtoD_full_stall = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) begin
        CtoD_exe_pc_sel = 2'($urandom_range(1, 2));
        CtoD_if_kill    = 1'($urandom_range(0, 1));
        pick = int'($urandom_range(0, 3));
        tmp  = $urandom();
        tmp[1:0] = 2'b00;
        exe_br_target = (pick == 0) ? 32'h100 : (pick == 1) ? 32'hFFFF_FFF8 : tmp;
        exe_jr_target = $urandom();
      end else begin
        CtoD_exe_pc_sel = 2'b00;
        CtoD_if_kill    = 1'b0;
      end
      cycle();
    end
    check("rand_progress", (pops - p0) > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
